// File: rtl/baw_input_ctrl.sv
// baw_input_ctrl: debounced button pulses and validated one-hot card selection
module baw_input_ctrl #(
   parameter int DB_LIMIT = 1_000_000,
   parameter int DB_W     = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [4:0] btn_raw,
   input  logic [8:0] sw_raw,
   input  logic [8:0] avail_mask,
   input  logic       sel_enable,
   input  logic       card_ack,
   output logic [4:0] btn_pulse,
   output logic       card_valid,
   output logic [8:0] card_sel,
   output logic       sel_error
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t state, state_n;
   logic [4:0] btn_m, btn_s, stable, stable_d;
   logic [8:0] sw_m, sw_s, sel_n;
   logic [DB_W-1:0] cnt [5];
   logic en_d, err_n, commit, ok, clr, abort;

   assign card_valid = state == HOLD;

   // two-flop synchronizers, sel_enable history and rising-edge pulse of the debounced levels
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_m     <= '0;
         btn_s     <= '0;
         sw_m      <= '0;
         sw_s      <= '0;
         en_d      <= 1'b0;
         stable_d  <= '0;
         btn_pulse <= '0;
      end else begin
         btn_m     <= btn_raw;
         btn_s     <= btn_m;
         sw_m      <= sw_raw;
         sw_s      <= sw_m;
         en_d      <= sel_enable;
         stable_d  <= stable;
         btn_pulse <= stable & ~stable_d;
      end
   end

   // per-button debounce: the stable level flips once the synced input has disagreed for DB_LIMIT-1 cycles
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stable <= '0;
         for (int i = 0; i < 5; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (btn_s[i] == stable[i]) cnt[i] <= '0;
            else if (cnt[i] == DB_W'(DB_LIMIT - 2)) begin
               cnt[i]    <= '0;
               stable[i] <= ~stable[i];
            end else cnt[i] <= cnt[i] + DB_W'(1);
         end
      end
   end

   // commit FSM state, held card and sticky error registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         card_sel  <= '0;
         sel_error <= 1'b0;
      end else begin
         state     <= state_n;
         card_sel  <= sel_n;
         sel_error <= err_n;
      end
   end

   // commit validation, hold/ack/abort transitions and error set/clear (set wins over clear)
   always_comb begin
      ok      = $onehot(sw_s) && |(sw_s & avail_mask);
      commit  = state == IDLE && btn_pulse[0] && sel_enable;
      clr     = (en_d && !sel_enable) || btn_pulse[2];
      abort   = !sel_enable || btn_pulse[2];
      state_n = state;
      sel_n   = card_sel;
      err_n   = commit ? !ok : (clr ? 1'b0 : sel_error);
      if (commit && ok) begin
         state_n = HOLD;
         sel_n   = sw_s;
      end else if (state == HOLD && (abort || card_ack)) begin
         state_n = IDLE;
         sel_n   = '0;
      end
   end
endmodule

// File: tb/tb_baw_input_ctrl.sv
// tb_baw_input_ctrl: directed stimulus with a sample-window reference model checked every cycle
module tb_baw_input_ctrl;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic [4:0] btn_raw;
   logic [8:0] sw_raw, avail_mask;
   logic       sel_enable, card_ack;
   logic [4:0] btn_pulse;
   logic       card_valid, sel_error;
   logic [8:0] card_sel;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int pcnt0 = 0;
   int lat, p0;

   baw_input_ctrl #(.DB_LIMIT(DB), .DB_W(4)) dut (
      .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .sw_raw(sw_raw),
      .avail_mask(avail_mask), .sel_enable(sel_enable), .card_ack(card_ack),
      .btn_pulse(btn_pulse), .card_valid(card_valid), .card_sel(card_sel),
      .sel_error(sel_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (btn_pulse[0]) pcnt0 <= pcnt0 + 1;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // reference model: raw sample history, window-based debounce, abstract held-card state
   logic [4:0] bh [DB];
   logic [8:0] sh0, sh1, m_card;
   logic [4:0] m_stable, m_pulse, rose;
   logic       m_valid, m_err, en_prev, m_commit, m_ok, m_clr, all_diff;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < DB; k++) bh[k] = '0;
         sh0 = '0; sh1 = '0; m_card = '0; m_stable = '0; m_pulse = '0; rose = '0;
         m_valid = 0; m_err = 0; en_prev = 0;
      end else begin
         m_commit = !m_valid && m_pulse[0] && sel_enable;
         m_ok = $countones(sh1) == 1 && (sh1 & avail_mask) != 0;
         m_clr = (en_prev && !sel_enable) || m_pulse[2];
         if (m_commit) m_err = !m_ok;
         else if (m_clr) m_err = 0;
         if (m_valid) begin
            if (!sel_enable || m_pulse[2] || card_ack) begin
               m_valid = 0;
               m_card = '0;
            end
         end else if (m_commit && m_ok) begin
            m_valid = 1;
            m_card = sh1;
         end
         en_prev = sel_enable;
         m_pulse = rose;
         for (int i = 0; i < 5; i++) begin
            all_diff = 1;
            for (int k = 1; k < DB; k++) if (bh[k][i] == m_stable[i]) all_diff = 0;
            rose[i] = all_diff && !m_stable[i];
            if (all_diff) m_stable[i] = !m_stable[i];
         end
         for (int k = DB - 1; k > 0; k--) bh[k] = bh[k-1];
         bh[0] = btn_raw;
         sh1 = sh0;
         sh0 = sw_raw;
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         check("btn_pulse", {4'b0, btn_pulse}, {4'b0, m_pulse});
         check("card_valid", {8'b0, card_valid}, {8'b0, m_valid});
         check("card_sel", card_sel, m_card);
         check("sel_error", {8'b0, sel_error}, {8'b0, m_err});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input int i, output int l);
      int start;
      start = cyc;
      l = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (btn_pulse[i]) begin
            l = cyc - start;
            break;
         end
      end
   endtask

   task automatic press(input int i);
      int l;
      btn_raw[i] = 1'b1;
      wait_pulse(i, l);
      check("press_latency", l[8:0], 9'd6);
      step(2);
      btn_raw[i] = 1'b0;
      step(6);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 0; btn_raw = '0; sw_raw = '0; avail_mask = 9'h1FF; sel_enable = 0; card_ack = 0;
      step(3);
      check("rst_valid", {8'b0, card_valid}, 9'd0);
      check("rst_sel", card_sel, 9'd0);
      check("rst_err", {8'b0, sel_error}, 9'd0);
      check("rst_pulse", {4'b0, btn_pulse}, 9'd0);
      resetn = 1;
      step(2);
      p0 = pcnt0;
      btn_raw[0] = 1; step(2);
      btn_raw[0] = 0; step(2);
      btn_raw[0] = 1;
      wait_pulse(0, lat);
      check("bounce_latency", lat[8:0], 9'd6);
      step(3);
      btn_raw[0] = 0;
      step(8);
      check("bounce_count", 9'(pcnt0 - p0), 9'd1);
      check("disabled_valid", {8'b0, card_valid}, 9'd0);
      check("disabled_err", {8'b0, sel_error}, 9'd0);

      sel_enable = 1; sw_raw = 9'h010;
      step(3);
      press(0);
      check("commit_valid", {8'b0, card_valid}, 9'd1);
      check("commit_sel", card_sel, 9'h010);
      card_ack = 1; step(1); card_ack = 0;
      check("ack_valid", {8'b0, card_valid}, 9'd0);
      check("ack_sel", card_sel, 9'd0);

      sw_raw = 9'h011; step(3); press(0);
      check("two_bits_err", {8'b0, sel_error}, 9'd1);
      check("two_bits_valid", {8'b0, card_valid}, 9'd0);
      press(2);
      check("bottom_clear_err", {8'b0, sel_error}, 9'd0);
      sw_raw = 9'h000; step(3); press(0);
      check("zero_bits_err", {8'b0, sel_error}, 9'd1);
      press(2);
      sw_raw = 9'h004; avail_mask = 9'h1FB; step(3); press(0);
      check("unavail_err", {8'b0, sel_error}, 9'd1);
      check("unavail_sel", card_sel, 9'd0);
      avail_mask = 9'h1FF; step(1); press(0);
      check("valid_clears_err", {8'b0, sel_error}, 9'd0);
      check("valid_sel", card_sel, 9'h004);

      sw_raw = 9'h002; step(3); press(0);
      check("hold_ignores", card_sel, 9'h004);

      btn_raw[2] = 1;
      wait_pulse(2, lat);
      card_ack = 1;
      @(posedge clk); #1 card_ack = 0;
      check("abort_valid", {8'b0, card_valid}, 9'd0);
      check("abort_sel", card_sel, 9'd0);
      step(2);
      btn_raw[2] = 0;
      step(6);

      sw_raw = 9'h011; step(3); press(0);
      check("pre_fall_err", {8'b0, sel_error}, 9'd1);
      sel_enable = 0; step(2);
      check("fall_clears_err", {8'b0, sel_error}, 9'd0);
      sel_enable = 1;

      sw_raw = 9'h001; step(3); press(0);
      check("pre_reset_valid", {8'b0, card_valid}, 9'd1);
      @(posedge clk); #2 resetn = 0;
      #1;
      check("async_valid", {8'b0, card_valid}, 9'd0);
      check("async_sel", card_sel, 9'd0);
      check("async_pulse", {4'b0, btn_pulse}, 9'd0);
      check("async_err", {8'b0, sel_error}, 9'd0);
      btn_raw[0] = 1;
      step(3);
      resetn = 1;
      wait_pulse(0, lat);
      check("held_after_reset_latency", lat[8:0], 9'd6);
      step(2);
      check("held_after_reset_commit", card_sel, 9'h001);
      btn_raw[0] = 0;
      step(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
